// File: rtl/ysyx_22040931_ifu_pkg.sv
// Shared types and constants for the ysyx_22040931 instruction fetch unit.
package ysyx_22040931_ifu_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StReq,
    StWait,
    StHold,
    StDrop
  } ifu_state_e;

  localparam logic [31:0] IfuNop     = 32'h0000_0013;
  localparam logic [63:0] IfuResetPc = 64'h8000_0000;
  localparam int unsigned OpcodeMsb  = 6;
  localparam int unsigned OpcodeLsb  = 0;

  function automatic logic is_misaligned(input logic [1:0] pc_lsb);
    return pc_lsb != 2'b00;
  endfunction

endpackage

// File: rtl/ysyx_22040931_ifu_pc.sv
// Fetch PC register with its next-pc mux (reset / redirect / sequential / hold).
module ysyx_22040931_ifu_pc
  import ysyx_22040931_ifu_pkg::*;
#(
  parameter int unsigned     XLEN     = 64,
  parameter logic [XLEN-1:0] RESET_PC = XLEN'(IfuResetPc)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            redirect,
  input  logic [XLEN-1:0] redirect_pc,
  input  logic            advance,
  output logic [XLEN-1:0] pc,
  output logic            next_misaligned
);

  logic [XLEN-1:0] pc_d, pc_q;

  always_comb begin
    pc_d = pc_q;
    if (redirect) begin
      pc_d = redirect_pc;
    end else if (advance) begin
      pc_d = pc_q + XLEN'(4);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q <= RESET_PC;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign pc              = pc_q;
  assign next_misaligned = is_misaligned(pc_d[1:0]);

endmodule

// File: rtl/ysyx_22040931_ifu.sv
// Instruction fetch unit: one outstanding imem request, valid/ready hand-off to decode.
// Optional performance counters are enabled with YSYX_22040931_IFU_PERF_EN.
module ysyx_22040931_ifu
  import ysyx_22040931_ifu_pkg::*;
#(
  parameter int unsigned     XLEN     = 64,
  parameter int unsigned     INST_W   = 32,
  parameter logic [XLEN-1:0] RESET_PC = XLEN'(IfuResetPc)
) (
  input  logic              clk,
  input  logic              rst,
  output logic              imem_req_valid,
  input  logic              imem_req_ready,
  output logic [XLEN-1:0]   imem_req_addr,
  input  logic              imem_resp_valid,
  input  logic [INST_W-1:0] imem_resp_data,
  input  logic              imem_resp_err,
  input  logic              redirect_valid,
  input  logic [XLEN-1:0]   redirect_pc,
  output logic              id_valid,
  input  logic              id_ready,
  output logic [XLEN-1:0]   id_pc,
  output logic [INST_W-1:0] id_inst,
  output logic [6:0]        id_opcode,
  output logic              id_fault
`ifdef YSYX_22040931_IFU_PERF_EN
  ,
  output logic [63:0]       perf_fetch_cnt,
  output logic [63:0]       perf_stall_cnt
`endif
);

  ifu_state_e        state_q, state_d;
  logic              req_valid_q, id_valid_q, id_fault_q;
  logic [XLEN-1:0]   id_pc_q;
  logic [INST_W-1:0] id_inst_q;
  logic [XLEN-1:0]   pc;
  logic              pc_next_misaligned, pc_misaligned;
  logic              redir, req_fire, advance;

  // Redirects are meaningless before the first fetch has been set up.
  assign redir         = redirect_valid && (state_q != StIdle);
  assign req_fire      = req_valid_q && imem_req_ready;
  assign pc_misaligned = is_misaligned(pc[1:0]);
  assign advance       = (state_q == StHold) && id_ready && !redir;

  ysyx_22040931_ifu_pc #(
    .XLEN     (XLEN),
    .RESET_PC (RESET_PC)
  ) u_pc (
    .clk             (clk),
    .rst             (rst),
    .redirect        (redir),
    .redirect_pc     (redirect_pc),
    .advance         (advance),
    .pc              (pc),
    .next_misaligned (pc_next_misaligned)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: state_d = StReq;
      StReq: begin
        if (redir) begin
          state_d = req_fire ? StDrop : StReq;
        end else if (pc_misaligned) begin
          state_d = StHold;
        end else if (req_fire) begin
          state_d = StWait;
        end
      end
      StWait: begin
        if (redir) begin
          state_d = imem_resp_valid ? StReq : StDrop;
        end else if (imem_resp_valid) begin
          state_d = StHold;
        end
      end
      StHold: begin
        if (redir || id_ready) begin
          state_d = StReq;
        end
      end
      // A redirect here keeps draining; only the stale response releases DROP.
      StDrop: begin
        if (imem_resp_valid) begin
          state_d = StReq;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      req_valid_q <= 1'b0;
      id_valid_q  <= 1'b0;
      id_fault_q  <= 1'b0;
      id_pc_q     <= RESET_PC;
      id_inst_q   <= INST_W'(IfuNop);
    end else begin
      state_q     <= state_d;
      // The request is pre-decided from the pc that REQ will hold next cycle.
      req_valid_q <= (state_d == StReq) && !pc_next_misaligned;
      id_valid_q  <= (state_d == StHold);
      if ((state_q == StWait) && !redir && imem_resp_valid) begin
        id_pc_q    <= pc;
        id_inst_q  <= imem_resp_err ? INST_W'(IfuNop) : imem_resp_data;
        id_fault_q <= imem_resp_err;
      end else if ((state_q == StReq) && !redir && pc_misaligned) begin
        id_pc_q    <= pc;
        id_inst_q  <= INST_W'(IfuNop);
        id_fault_q <= 1'b1;
      end
    end
  end

  assign imem_req_valid = req_valid_q;
  assign imem_req_addr  = pc;
  assign id_valid       = id_valid_q;
  assign id_pc          = id_pc_q;
  assign id_inst        = id_inst_q;
  assign id_opcode      = id_inst_q[OpcodeMsb:OpcodeLsb];
  assign id_fault       = id_fault_q;

`ifdef YSYX_22040931_IFU_PERF_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_fetch_cnt <= '0;
      perf_stall_cnt <= '0;
    end else begin
      if (id_valid_q && id_ready) begin
        perf_fetch_cnt <= perf_fetch_cnt + 64'd1;
      end
      if (((state_q == StReq) && !imem_req_ready) || (state_q == StWait)) begin
        perf_stall_cnt <= perf_stall_cnt + 64'd1;
      end
    end
  end
`endif

endmodule
